// File: rtl/cpu_mem_pkg.sv
// Purpose : shared definitions for the unified-memory arbiter.
//           Arbiter state encoding, owner encoding and the default memory latency.
// Contents: arb_state_e (ARB_IDLE, ARB_BUSY), owner_e (OWN_I=0, OWN_D=1), MEM_LATENCY.
package cpu_mem_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int MEM_LATENCY = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose : combinational grant selection between the fetch (I) and data (D) ports.
// Macro   : MEM_ARB_RR_EN -- when defined, a tie goes to the side not served last
//           (round-robin). When undefined, D always beats I and no `last` input exists.
// Ports   : i_req, d_req  in   request pair
//           last          in   side granted most recently (MEM_ARB_RR_EN only)
//           grant         out  at least one request is pending
//           owner         out  winning side (OWN_D when nothing requests)
module mem_arb_pick
  import cpu_mem_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef MEM_ARB_RR_EN
  input  owner_e last,
`endif
  output logic   grant,
  output owner_e owner
);

  // Winner selection; D wins ties by default because it carries the older instruction.
  always_comb begin
    grant = i_req | d_req;
    owner = OWN_D;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      if (last == OWN_D) begin
        owner = OWN_I;
      end else begin
        owner = OWN_D;
      end
`else
      owner = OWN_D;
`endif
    end else if (i_req) begin
      owner = OWN_I;
    end else begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : shares one single-port, multi-cycle memory between instruction fetch (I)
//           and the MEM-stage data port (D). Each access is grant, LATENCY busy cycles
//           with mem_en held, and a one-cycle ack carrying the read data.
// Macro   : MEM_ARB_RR_EN -- round-robin tie break (see mem_arb_pick); default D-over-I.
// Ports   : clk, rst (sync, active high)
//           i_req/i_addr -> i_rdata/i_ack            fetch side
//           d_req/d_wr/d_addr/d_wdata -> d_rdata/d_ack  data side
//           mem_en/mem_wr/mem_addr/mem_wdata, mem_rdata  memory side
//           busy                                       high whenever not IDLE
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  owner_e        owner_q, owner_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_wr_q, mem_wr_d;
  logic          busy_q, busy_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          pick_grant;
  owner_e        pick_owner;

`ifdef MEM_ARB_RR_EN
  owner_e        last_q, last_d;
`endif

  mem_arb_pick u_pick (
    .i_req (i_req),
    .d_req (d_req),
`ifdef MEM_ARB_RR_EN
    .last  (last_q),
`endif
    .grant (pick_grant),
    .owner (pick_owner)
  );

  // Next-state logic: grant in IDLE latches the winner's fields; BUSY counts to LATENCY-1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_grant) begin
          state_d = ARB_BUSY;
          cnt_d   = {CW{1'b0}};
          owner_d = pick_owner;
`ifdef MEM_ARB_RR_EN
          last_d  = pick_owner;
`endif
          if (pick_owner == OWN_D) begin
            wr_d        = d_wr;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            // Fetches never write.
            wr_d        = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = {DW{1'b0}};
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ARB_IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase

    // Outputs are registered: decode them from the next state so they line up
    // with the cycle the state register enters.
    busy_d   = (state_d == ARB_BUSY);
    mem_en_d = busy_d;
    mem_wr_d = busy_d & wr_d;
    i_ack_d  = busy_d && (cnt_d == CNT_LAST) && (owner_d == OWN_I);
    d_ack_d  = busy_d && (cnt_d == CNT_LAST) && (owner_d == OWN_D);
  end

  // State and registered outputs; reset abandons any access in flight without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= {CW{1'b0}};
      owner_q     <= OWN_D;
      wr_q        <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q      <= OWN_I;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      busy_q      <= busy_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  // Memory data is only valid in the ack cycle, so it is steered straight through
  // to the owner; the other side reads zero.
  assign i_rdata   = i_ack_q ? mem_rdata : {DW{1'b0}};
  assign d_rdata   = d_ack_q ? mem_rdata : {DW{1'b0}};

endmodule
